ccc_lock_sequencer: RTL

//  Start-up / recovery controller for the fabric CCC PLL (RCOSC_25_50MHZ ref, GL0 out).

---
 rtl/ccc_lock_sequencer_if.sv | 19 +
 rtl/ccc_lock_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ccc_lock_sequencer_if.sv
// ccc_lock_sequencer_if: CCC PLL control bundle; master = sequencer (LOCK/RETRY_REQ in, PLL/fabric controls and status out), slave = PLL/fabric side
interface ccc_lock_sequencer_if #(parameter int CNT_W = 8) ();
  logic             LOCK;
  logic             RETRY_REQ;
  logic             PLL_ARST_N;
  logic             PLL_POWERDOWN_N;
  logic             FABRIC_RESET_N;
  logic             READY;
  logic             LOCK_FAULT;
  logic [CNT_W-1:0] RELOCK_COUNT;
  modport master (
    input  LOCK, RETRY_REQ,
    output PLL_ARST_N, PLL_POWERDOWN_N, FABRIC_RESET_N, READY, LOCK_FAULT, RELOCK_COUNT
  );
  modport slave (
    output LOCK, RETRY_REQ,
    input  PLL_ARST_N, PLL_POWERDOWN_N, FABRIC_RESET_N, READY, LOCK_FAULT, RELOCK_COUNT
  );
endinterface

// File: rtl/ccc_lock_sequencer.sv
// ccc_lock_sequencer: CCC PLL start-up/relock sequencer on RCOSC_25_50MHZ with sync active-high RESET; bus (master) carries LOCK/RETRY_REQ in and PLL_ARST_N/PLL_POWERDOWN_N/FABRIC_RESET_N/READY/LOCK_FAULT/RELOCK_COUNT out; CCC_SEQ_POWERDOWN_EN powers the PLL down in FAULT
module ccc_lock_sequencer #(
  parameter int ARST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 8
) (
  input logic RCOSC_25_50MHZ,
  input logic RESET,
  ccc_lock_sequencer_if.master bus
);
  localparam int TMAX = (LOCK_TIMEOUT > ARST_CYCLES) ? LOCK_TIMEOUT : ARST_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] ARST_LAST = TW'(ARST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRIES);
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, LOST, FAULT} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [RW-1:0] retries_q, retries_d;
  logic [CNT_W-1:0] relock_q, relock_d;
  logic lock_meta_q, lock_meta_d, lock_s_q, lock_s_d;
  logic pll_arst_n_q, pll_arst_n_d, pll_pd_n_q, pll_pd_n_d;
  logic fabric_reset_n_q, fabric_reset_n_d, ready_q, ready_d, lock_fault_q, lock_fault_d;
  always_comb begin
    lock_meta_d = bus.LOCK;
    lock_s_d = lock_meta_q;
    state_d = state_q;
    timer_d = timer_q;
    stab_d = stab_q;
    retries_d = retries_q;
    case (state_q)
      PLL_RST: begin
        state_d = (timer_q == ARST_LAST) ? WAIT_LOCK : PLL_RST;
        timer_d = (timer_q == ARST_LAST) ? '0 : timer_q + 1'b1;
      end
      WAIT_LOCK:
        if (lock_s_q) begin
          state_d = STABLE;
          timer_d = '0;
          stab_d = '0;
        end else if (timer_q == TO_LAST) begin
          retries_d = retries_q + 1'b1;
          state_d = (retries_d == R_MAX) ? FAULT : PLL_RST;
          timer_d = '0;
        end else timer_d = timer_q + 1'b1;
      STABLE:
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
          stab_d = '0;
        end else if (stab_q == ST_LAST) begin
          state_d = RUN;
          stab_d = '0;
          retries_d = '0;
        end else stab_d = stab_q + 1'b1;
      RUN: state_d = lock_s_q ? RUN : LOST;
      LOST: begin
        state_d = PLL_RST;
        timer_d = '0;
      end
      FAULT:
        if (bus.RETRY_REQ) begin
          state_d = PLL_RST;
          timer_d = '0;
          retries_d = '0;
        end
      default: state_d = PLL_RST;
    endcase
    relock_d = (state_d == LOST && state_q == RUN && relock_q != '1) ? relock_q + 1'b1 : relock_q;
    pll_arst_n_d = !(state_d == PLL_RST || state_d == FAULT);
`ifdef CCC_SEQ_POWERDOWN_EN
    pll_pd_n_d = state_d != FAULT;
`else
    pll_pd_n_d = 1'b1;
`endif
    fabric_reset_n_d = state_d == RUN;
    ready_d = state_d == RUN;
    lock_fault_d = state_d == FAULT;
  end
  always_ff @(posedge RCOSC_25_50MHZ) begin
    if (RESET) begin
      state_q <= PLL_RST;
      timer_q <= '0;
      stab_q <= '0;
      retries_q <= '0;
      relock_q <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q <= 1'b0;
      pll_arst_n_q <= 1'b0;
      pll_pd_n_q <= 1'b1;
      fabric_reset_n_q <= 1'b0;
      ready_q <= 1'b0;
      lock_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stab_q <= stab_d;
      retries_q <= retries_d;
      relock_q <= relock_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q <= lock_s_d;
      pll_arst_n_q <= pll_arst_n_d;
      pll_pd_n_q <= pll_pd_n_d;
      fabric_reset_n_q <= fabric_reset_n_d;
      ready_q <= ready_d;
      lock_fault_q <= lock_fault_d;
    end
  end
  assign bus.PLL_ARST_N = pll_arst_n_q;
  assign bus.PLL_POWERDOWN_N = pll_pd_n_q;
  assign bus.FABRIC_RESET_N = fabric_reset_n_q;
  assign bus.READY = ready_q;
  assign bus.LOCK_FAULT = lock_fault_q;
  assign bus.RELOCK_COUNT = relock_q;
endmodule
